// File: rtl/output_frame_sequencer.sv
// output_frame_sequencer: two-bank frame handoff between a producer and an output fetch stage.
//   clock, reset_n            : single clock, asynchronous active-low reset
//   enable                    : permits starting a new output frame
//   wr_frame_done             : producer finished writing bank write_bank (1-cycle pulse)
//   fetch_valid               : byte-valid strobe from the fetch stage
//   start                     : run request to the fetch stage
//   output_base_offset        : bank being fetched
//   write_bank                : bank the producer writes next
//   bank_full                 : per-bank frame-ready flags
//   frame_active              : high in LOAD and STREAM
//   overrun                   : sticky, producer overwrote an unread frame
//   frames_out                : completed output frame count (wraps)
module output_frame_sequencer #(
  parameter int FRAME_WORDS    = 19200,
  parameter int BYTES_PER_WORD = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       wr_frame_done,
  input  logic       fetch_valid,
  output logic       start,
  output logic       output_base_offset,
  output logic       write_bank,
  output logic [1:0] bank_full,
  output logic       frame_active,
  output logic       overrun,
  output logic [7:0] frames_out
);
  localparam logic [18:0] LAST = 19'(FRAME_WORDS * BYTES_PER_WORD - 1);
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;
  state_t      state;
  logic        rd_ptr;
  logic [18:0] count;
  logic [1:0]  rel;
  logic [1:0]  nf;
  logic        guard;
  // rel is bank_full after DONE releases the streamed bank, so a bank freed this
  // cycle already counts as free for the producer's write rule.
  always_comb begin
    rel   = bank_full & ~((state == DONE) ? (2'b01 << rd_ptr) : 2'b00);
    nf    = rel | (2'b01 << write_bank);
    guard = (state == LOAD || state == STREAM) && write_bank == rd_ptr;
  end
  assign frame_active = state == LOAD || state == STREAM;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      start              <= 1'b0;
      output_base_offset <= 1'b0;
      write_bank         <= 1'b0;
      rd_ptr             <= 1'b0;
      bank_full          <= 2'b00;
      overrun            <= 1'b0;
      frames_out         <= 8'd0;
      count              <= '0;
    end else begin
      // A pulse aimed at the bank being streamed must not mark it full again.
      bank_full <= (wr_frame_done && !guard) ? nf : rel;
      if (wr_frame_done && !guard && !rel[~write_bank])
        write_bank <= ~write_bank;
      // Overrun: writing into the streamed bank, or both banks already hold unread frames.
      if (wr_frame_done && (guard || (rel[write_bank] && rel[~write_bank])))
        overrun <= 1'b1;
      case (state)
        IDLE: if (enable && bank_full[rd_ptr]) state <= LOAD;
        LOAD: begin
          output_base_offset <= rd_ptr;
          count              <= '0;
          start              <= 1'b1;
          state              <= STREAM;
        end
        STREAM: if (fetch_valid) begin
          count <= count + 19'd1;
          if (count == LAST) begin
            start <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          rd_ptr     <= ~rd_ptr;
          frames_out <= frames_out + 8'd1;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_output_frame_sequencer.sv
// tb_output_frame_sequencer: random stimulus against a frame/bank bookkeeping model.
module tb_output_frame_sequencer;
  localparam int FW = 2;
  localparam int BPW = 3;
  localparam int N = FW * BPW;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       wr_frame_done = 1'b0;
  logic       fetch_valid = 1'b0;
  logic       start;
  logic       output_base_offset;
  logic       write_bank;
  logic [1:0] bank_full;
  logic       frame_active;
  logic       overrun;
  logic [7:0] frames_out;
  int checks = 0;
  int errors = 0;
  bit [1:0] m_full;
  bit       m_wb, m_rd, m_obo, m_ovr, m_busy, m_load, m_fin;
  bit [7:0] m_frames;
  int       m_left;
  bit       rst_done = 0;
  output_frame_sequencer #(.FRAME_WORDS(FW), .BYTES_PER_WORD(BPW)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .wr_frame_done(wr_frame_done),
    .fetch_valid(fetch_valid), .start(start), .output_base_offset(output_base_offset),
    .write_bank(write_bank), .bank_full(bank_full), .frame_active(frame_active),
    .overrun(overrun), .frames_out(frames_out)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_full = 2'b00; m_wb = 0; m_rd = 0; m_obo = 0; m_ovr = 0;
    m_busy = 0; m_load = 0; m_fin = 0; m_frames = 0; m_left = 0;
  endtask
  task automatic check_all();
    check("start", start, m_busy && !m_load && !m_fin);
    check("frame_active", frame_active, m_busy && !m_fin);
    check("base_offset", output_base_offset, m_obo);
    check("write_bank", write_bank, m_wb);
    check("bank_full", bank_full, m_full);
    check("overrun", overrun, m_ovr);
    check("frames_out", frames_out, m_frames);
  endtask
  // One clock of the model: a frame is busy from its load cycle through its finish
  // cycle; the finishing frame frees its bank before the producer's write is judged.
  task automatic model_step(input bit en, input bit wfd, input bit fv);
    bit [1:0] rel;
    bit ready;
    rel = m_full;
    ready = m_full[m_rd];
    if (m_fin) rel[m_rd] = 0;
    if (wfd) begin
      if (m_busy && !m_fin && m_wb == m_rd) m_ovr = 1;
      else begin
        if (rel[m_wb] && rel[!m_wb]) m_ovr = 1;
        rel[m_wb] = 1;
        if (!rel[!m_wb]) m_wb = !m_wb;
      end
    end
    m_full = rel;
    if (m_fin) begin
      m_rd = !m_rd;
      m_frames = m_frames + 8'd1;
      m_busy = 0;
      m_fin = 0;
    end else if (m_busy && m_load) begin
      m_load = 0;
      m_obo = m_rd;
      m_left = N;
    end else if (m_busy) begin
      if (fv) begin
        m_left--;
        if (m_left == 0) m_fin = 1;
      end
    end else if (en && ready) begin
      m_busy = 1;
      m_load = 1;
    end
  endtask
  initial begin
    bit en_hold;
    model_reset();
    #2;
    check_all();
    #10 reset_n = 1'b1;
    en_hold = 1;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clock);
      check_all();
      if (c > 2500 && !rst_done && m_busy && !m_load && !m_fin) begin
        rst_done = 1;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_start", start, 1'b0);
        check_all();
        reset_n = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) en_hold = !en_hold;
      enable = en_hold;
      wr_frame_done = (c == 0) ? 1'b1 : ($urandom_range(0, 9) == 0);
      fetch_valid = $urandom_range(0, 9) < 6;
      @(posedge clock);
      model_step(enable, wr_frame_done, fetch_valid);
    end
    @(negedge clock);
    check_all();
    check("reset_hit", rst_done, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
